// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM states, next-PC source codes
// and the fixed instruction size.
package pc_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ   = 3'd0,
        SRC_HOLD  = 3'd1,
        SRC_BR    = 3'd2,
        SRC_JALR  = 3'd3,
        SRC_TRAP  = 3'd4,
        SRC_MRET  = 3'd5,
        SRC_MISAL = 3'd6
    } src_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: fixed-priority source pick plus the
// alignment check that turns a bad branch/JALR target into a trap entry.
module pc_next_sel #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = 32'h0000_0100
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] seq_pc_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            hold_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jalr_taken_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic            trap_req_i,
    input  logic            mret_req_i,
    output logic [2:0]      src_o,
    output logic [XLEN-1:0] next_pc_o
);
    import pc_pkg::*;

    src_t            src;
    logic [XLEN-1:0] jalr_t;

    // JALR clears bit 0 before the alignment check, so only bit 1 can fault.
    assign jalr_t = jalr_target_i & ~{{(XLEN-1){1'b0}}, 1'b1};

    always_comb begin
        src       = SRC_SEQ;
        next_pc_o = seq_pc_i;
        if (trap_req_i) begin
            src       = SRC_TRAP;
            next_pc_o = TRAP_VECTOR;
        end else if (mret_req_i) begin
            src       = SRC_MRET;
            next_pc_o = epc_i;
        end else if (jalr_taken_i) begin
            if (jalr_t[1:0] != 2'b00) begin
                src       = SRC_MISAL;
                next_pc_o = TRAP_VECTOR;
            end else begin
                src       = SRC_JALR;
                next_pc_o = jalr_t;
            end
        end else if (br_taken_i) begin
            if (br_target_i[1:0] != 2'b00) begin
                src       = SRC_MISAL;
                next_pc_o = TRAP_VECTOR;
            end else begin
                src       = SRC_BR;
                next_pc_o = br_target_i;
            end
        end else if (hold_i) begin
            src       = SRC_HOLD;
            next_pc_o = pc_i;
        end
    end

    assign src_o = src;

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: PC/EPC registers and the boot/run/halt control FSM.
// state_o exposes the FSM state for debug and checkers.
module pc_gen #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
    parameter int               INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jalr_taken,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap_req,
    input  logic            mret_req,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            misaligned_exc,
    output logic            halted,
    output logic [1:0]      state_o
);
    import pc_pkg::*;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misal_q, misal_d;
    logic [2:0]      src;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

    // A halt request suppresses sequential advance on its own edge.
    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_sel (
        .pc_i          (pc_q),
        .seq_pc_i      (pc_plus4),
        .epc_i         (epc_q),
        .hold_i        (stall | halt_req),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .jalr_taken_i  (jalr_taken),
        .jalr_target_i (jalr_target),
        .trap_req_i    (trap_req),
        .mret_req_i    (mret_req),
        .src_o         (src),
        .next_pc_o     (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        misal_d = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                pc_d = next_pc;
                if (src == SRC_TRAP || src == SRC_MISAL) epc_d = pc_q;
                misal_d = (src == SRC_MISAL);
                if (halt_req) state_d = S_HALT;
            end
            S_HALT: begin
                if (resume_req && !halt_req) state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            misal_q <= misal_d;
        end
    end

    assign pc             = pc_q;
    assign epc            = epc_q;
    assign misaligned_exc = misal_q;
    assign pc_valid       = (state_q == S_RUN);
    assign halted         = (state_q == S_HALT);
    assign state_o        = state_q;

endmodule
